pipelined_adder_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It is the next generation of the team's 32-bit combinational adder.
- The carry chain is split into STAGES equal chunks, with one pipeline register per chunk, to raise Fmax.
- Adds carry-in, a subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand-issue logic and result write-back in arithmetic datapaths.

---
 rtl/pipelined_adder_sub.sv | 163 ++++++++++++++++
 tb/tb_pipelined_adder_sub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub.sv
// ============================================================================
// pipelined_adder_sub
// ----------------------------------------------------------------------------
// Pipelined two's-complement adder/subtractor. The carry chain is split into
// STAGES chunks of CW = WIDTH/STAGES bits. Each stage adds one chunk and
// registers the result. Backpressure from the output side stalls every stage
// at once.
//
// Parameters
//   WIDTH   operand/result width; must be an integer multiple of STAGES
//   STAGES  number of pipeline stages (1..WIDTH); latency equals STAGES
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset; clears all state
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (= not stalled)
//   a, b       operands
//   cin        carry-in (add mode only)
//   sub        0: a + b + cin ; 1: a - b (cin ignored)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result this cycle
//   sum        result, mod 2^WIDTH
//   cout       carry out of the MSB (in sub mode 1 = no borrow)
//   ovf        signed overflow of the operation
// ============================================================================
module pipelined_adder_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pipeline registers, one entry per stage.
    //
    // r_acc packs the already-computed sum chunks (low end) together with the
    // not-yet-added chunks of operand a (high end). After stage k, chunks
    // 0..k hold sum bits and chunks k+1.. still hold a bits, so after the last
    // stage r_acc is the complete sum.
    //
    // r_bx carries the (possibly inverted) b operand down the pipe; its MSB
    // is also needed at the end for the overflow flag.
    //
    // r_amsb keeps the original MSB of a, since r_acc overwrites it with the
    // sum MSB in the final stage.
    // ------------------------------------------------------------------------
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_acc   [STAGES];
    logic [WIDTH-1:0] r_bx    [STAGES];
    logic             r_carry [STAGES];
    logic             r_amsb  [STAGES];

    // Stage inputs: ports for stage 0, previous registers otherwise.
    logic             w_valid_in [STAGES];
    logic [WIDTH-1:0] w_acc_in   [STAGES];
    logic [WIDTH-1:0] w_bx_in    [STAGES];
    logic             w_carry_in [STAGES];
    logic             w_amsb_in  [STAGES];

    // Global stall: the last stage holds an unaccepted result, so nothing in
    // the pipe may move.
    logic w_stall;

    assign w_stall  = r_valid[STAGES-1] && !out_ready;
    assign in_ready = !w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CW:0]      w_chunk_sum;
            logic [WIDTH-1:0] w_acc_next;

            if (gi == 0) begin : g_src_port
                // Subtraction as a + ~b + 1: invert b and force the carry-in.
                assign w_valid_in[gi] = in_valid;
                assign w_acc_in[gi]   = a;
                assign w_bx_in[gi]    = sub ? ~b : b;
                assign w_carry_in[gi] = sub ? 1'b1 : cin;
                assign w_amsb_in[gi]  = a[MSB];
            end else begin : g_src_reg
                assign w_valid_in[gi] = r_valid[gi-1];
                assign w_acc_in[gi]   = r_acc[gi-1];
                assign w_bx_in[gi]    = r_bx[gi-1];
                assign w_carry_in[gi] = r_carry[gi-1];
                assign w_amsb_in[gi]  = r_amsb[gi-1];
            end

            // Chunk adder for this stage; the extra top bit is the chunk carry.
            assign w_chunk_sum = {1'b0, w_acc_in[gi][gi*CW +: CW]}
                               + {1'b0, w_bx_in[gi][gi*CW +: CW]}
                               + {{CW{1'b0}}, w_carry_in[gi]};

            // Replace chunk gi of the accumulator (an a chunk) with its sum.
            always_comb begin
                w_acc_next                 = w_acc_in[gi];
                w_acc_next[gi*CW +: CW]    = w_chunk_sum[CW-1:0];
            end

            // Valid always advances when not stalled so bubbles flow through.
            // Data only loads behind a valid beat, which keeps the data path
            // quiet during bubbles and keeps undriven inputs out of the pipe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_acc[gi]   <= '0;
                    r_bx[gi]    <= '0;
                    r_carry[gi] <= 1'b0;
                    r_amsb[gi]  <= 1'b0;
                end else if (!w_stall) begin
                    r_valid[gi] <= w_valid_in[gi];
                    if (w_valid_in[gi]) begin
                        r_acc[gi]   <= w_acc_next;
                        r_bx[gi]    <= w_bx_in[gi];
                        r_carry[gi] <= w_chunk_sum[CW];
                        r_amsb[gi]  <= w_amsb_in[gi];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs come straight from the last stage, so they are stable while
    // stalled.
    // Overflow: both addends share a sign and the sum's sign differs.
    // ------------------------------------------------------------------------
    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_acc[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = (r_amsb[STAGES-1] == r_bx[STAGES-1][MSB])
                    && (r_acc[STAGES-1][MSB] != r_amsb[STAGES-1]);

    // Only the MSB of the final-stage b copy feeds the overflow flag.
    generate
        if (WIDTH > 1) begin : g_bx_tail
            logic w_unused_bx_low;
            assign w_unused_bx_low = ^r_bx[STAGES-1][MSB-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_adder_sub.sv
module tb_pipelined_adder_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- (8,1) ----------------
    logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;
    // ---------------- (16,2) ---------------
    logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;
    // ---------------- (32,4) ---------------
    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, s32;
    // ---------------- (64,8) ---------------
    logic        iv64, ir64, cin64, sub64, ov64, or64, co64, of64;
    logic [63:0] a64, b64, s64;

    pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8));
    pipelined_adder_sub #(.WIDTH(16), .STAGES(2)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16));
    pipelined_adder_sub #(.WIDTH(32), .STAGES(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32));
    pipelined_adder_sub #(.WIDTH(64), .STAGES(8)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
        .cout(co64), .ovf(of64));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [12];

    localparam int N = 40;
    logic [63:0] ra [N];
    logic [63:0] rb [N];
    logic        rc [N];
    logic        rs [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unsigned math for sum/cout, true signed math for ovf.
    task automatic ref_model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                             input logic ci, input logic si,
                             output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] mask;
        logic [65:0] am, bm, u, ta, tb;
        logic signed [65:0] sa, sb, st, smax, smin;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am = {2'b00, ai & mask};
        bm = {2'b00, bi & mask};
        if (si) begin
            u  = am - bm;
            co = (am >= bm);
        end else begin
            u  = am + bm + {65'd0, ci};
            co = ((u >> w) != 66'd0);
        end
        s  = u[63:0] & mask;
        ta = am << (66 - w);
        tb = bm << (66 - w);
        sa = $signed(ta) >>> (66 - w);
        sb = $signed(tb) >>> (66 - w);
        st = si ? (sa - sb) : (sa + sb + $signed({65'd0, ci}));
        smax = (66'sd1 <<< (w - 1)) - 66'sd1;
        smin = -(66'sd1 <<< (w - 1));
        ov = (st > smax) || (st < smin);
    endtask

    // Beat accepted at edge c-(s-1) must be on the outputs after edge c.
    task automatic check_out(input int w, input int s, input int c, input logic ovld,
                             input logic [63:0] sm, input logic co, input logic of);
        int idx;
        logic [63:0] es;
        logic eco, eov;
        idx = c - (s - 1);
        if (idx >= 0 && idx < N) begin
            ref_model(w, ra[idx], rb[idx], rc[idx], rs[idx], es, eco, eov);
            chk1($sformatf("sweep w%0d beat%0d valid", w, idx), ovld, 1'b1);
            chk64($sformatf("sweep w%0d beat%0d sum", w, idx), sm, es);
            chk1($sformatf("sweep w%0d beat%0d cout", w, idx), co, eco);
            chk1($sformatf("sweep w%0d beat%0d ovf", w, idx), of, eov);
        end else begin
            chk1($sformatf("sweep w%0d cycle%0d idle valid", w, c), ovld, 1'b0);
        end
    endtask

    initial begin
        int sent, recv, stall_left;
        logic stall_done;
        logic [31:0] held;
        logic [7:0] pat;

        vecs[0]  = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[6]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};

        for (int i = 0; i < N; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rc[i] = 1'($urandom_range(1, 0));
            rs[i] = 1'($urandom_range(1, 0));
        end
        ra[0] = {64{1'b1}}; rb[0] = 64'd1; rc[0] = 1'b0; rs[0] = 1'b0;
        ra[1] = 64'd0;      rb[1] = 64'd1; rc[1] = 1'b1; rs[1] = 1'b1;

        rst = 1'b1;
        iv8 = 0;  a8 = '0;  b8 = '0;  cin8 = 0;  sub8 = 0;  or8 = 1;
        iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; or16 = 1;
        iv32 = 0; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0; or32 = 1;
        iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; sub64 = 0; or64 = 1;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state ----
        chk1("reset out_valid", ov32, 1'b0);
        chk64("reset sum", {32'd0, s32}, 64'd0);
        chk1("reset cout", co32, 1'b0);
        chk1("reset ovf", of32, 1'b0);
        chk1("reset in_ready", ir32, 1'b1);
        chk1("reset out_valid w64", ov64, 1'b0);

        // ---- directed vectors, one at a time, latency checked ----
        for (int i = 0; i < 12; i++) begin
            a32 = vecs[i].a; b32 = vecs[i].b; cin32 = vecs[i].cin; sub32 = vecs[i].sub;
            iv32 = 1'b1;
            tick();
            iv32 = 1'b0;
            tick();
            tick();
            chk1($sformatf("vec%0d early valid", i), ov32, 1'b0);
            tick();
            chk1($sformatf("vec%0d valid", i), ov32, 1'b1);
            chk64($sformatf("vec%0d sum", i), {32'd0, s32}, {32'd0, vecs[i].s});
            chk1($sformatf("vec%0d cout", i), co32, vecs[i].co);
            chk1($sformatf("vec%0d ovf", i), of32, vecs[i].ov);
            $display("vec%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s32, co32, of32);
        end
        tick();

        // ---- streaming with a 3-cycle stall ----
        sent = 0; recv = 0; stall_left = 0; stall_done = 1'b0; held = '0;
        cin32 = 1'b0; sub32 = 1'b0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            if (!stall_done && ov32 && recv == 3) begin
                stall_left = 3;
                stall_done = 1'b1;
                held = s32;
            end
            or32 = (stall_left > 0) ? 1'b0 : 1'b1;
            iv32 = (sent < 8);
            a32  = sent;
            b32  = sent * 3;
            #1;
            if (stall_left > 0) begin
                chk1($sformatf("stall c%0d in_ready", c), ir32, 1'b0);
                chk1($sformatf("stall c%0d out_valid", c), ov32, 1'b1);
                chk64($sformatf("stall c%0d held sum", c), {32'd0, s32}, {32'd0, held});
                stall_left--;
            end else if (ov32) begin
                chk64($sformatf("stream beat%0d sum", recv), {32'd0, s32}, 64'(4 * recv));
                $display("stream beat%0d sum=%h", recv, s32);
                recv++;
            end
            if (iv32 && ir32) sent++;
            tick();
        end
        or32 = 1'b1;
        iv32 = 1'b0;
        chk64("stream received count", 64'(recv), 64'd8);
        chk1("stream stall seen", stall_done, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1($sformatf("stream drain%0d out_valid", k), ov32, 1'b0);
        end

        // ---- bubbles: out_valid follows in_valid delayed by 4 ----
        pat = 8'b01010101;
        for (int c = 0; c < 12; c++) begin
            iv32 = (c < 8) ? pat[c] : 1'b0;
            a32  = 32'h100 + c;
            b32  = 32'd0;
            tick();
            if (c >= 3 && (c - 3) < 8) begin
                chk1($sformatf("bubble c%0d out_valid", c), ov32, pat[c-3]);
                if (pat[c-3])
                    chk64($sformatf("bubble c%0d sum", c), {32'd0, s32}, 64'(32'h100 + c - 3));
            end else begin
                chk1($sformatf("bubble c%0d out_valid", c), ov32, 1'b0);
            end
        end
        iv32 = 1'b0;

        // ---- reset with 3 beats in flight; beat offered during reset dropped ----
        iv32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a32 = 32'h200 + i;
            tick();
        end
        rst  = 1'b1;
        a32  = 32'hDEAD;
        tick();
        rst  = 1'b0;
        iv32 = 1'b0;
        chk1("midreset out_valid", ov32, 1'b0);
        chk64("midreset sum", {32'd0, s32}, 64'd0);
        chk1("midreset cout", co32, 1'b0);
        chk1("midreset in_ready", ir32, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk1($sformatf("postreset%0d out_valid", k), ov32, 1'b0);
        end

        // ---- parameter sweep, all four instances in lock-step ----
        for (int c = 0; c < N + 9; c++) begin
            if (c < N) begin
                a8  = ra[c][7:0];  b8  = rb[c][7:0];  cin8  = rc[c]; sub8  = rs[c]; iv8  = 1'b1;
                a16 = ra[c][15:0]; b16 = rb[c][15:0]; cin16 = rc[c]; sub16 = rs[c]; iv16 = 1'b1;
                a32 = ra[c][31:0]; b32 = rb[c][31:0]; cin32 = rc[c]; sub32 = rs[c]; iv32 = 1'b1;
                a64 = ra[c];       b64 = rb[c];       cin64 = rc[c]; sub64 = rs[c]; iv64 = 1'b1;
            end else begin
                iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
            end
            tick();
            check_out(8,  1, c, ov8,  {56'd0, s8},  co8,  of8);
            check_out(16, 2, c, ov16, {48'd0, s16}, co16, of16);
            check_out(32, 4, c, ov32, {32'd0, s32}, co32, of32);
            check_out(64, 8, c, ov64, s64,          co64, of64);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
